// File: rtl/vga_timing_detector.sv
// vga_timing_detector: recovers line/frame timing from a raw hsync/vsync/RGB
// stream, locks after LOCK_FRAMES consecutive frames with the expected totals,
// then emits data-enable, active-pixel coordinates and pixel data.
module vga_timing_detector #(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic [VIDEO_WIDTH-1:0] i_red,
    input  logic [VIDEO_WIDTH-1:0] i_green,
    input  logic [VIDEO_WIDTH-1:0] i_blue,
    output logic                   o_locked,
    output logic                   o_de,
    output logic [CNT_W-1:0]       o_x,
    output logic [CNT_W-1:0]       o_y,
    output logic [VIDEO_WIDTH-1:0] o_red,
    output logic [VIDEO_WIDTH-1:0] o_green,
    output logic [VIDEO_WIDTH-1:0] o_blue,
    output logic [CNT_W-1:0]       o_line_len,
    output logic [CNT_W-1:0]       o_frame_lines,
    output logic                   o_err
);

    localparam logic             POL    = (SYNC_POL != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOT_C  = CNT_W'(TOTAL_COLS);
    localparam logic [CNT_W-1:0] TOT_R  = CNT_W'(TOTAL_ROWS);
    localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_START + ACTIVE_COLS);
    localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_START + ACTIVE_ROWS);
    localparam logic [7:0]       LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [7:0] good_cnt, good_nxt;
    logic       err_nxt;

    logic s1_h, s2_h, s3_h, s1_v, s2_v, s3_v;
    logic [VIDEO_WIDTH-1:0] s1_r, s1_g, s1_b, s2_r, s2_g, s2_b;

    logic [CNT_W-1:0] h_cnt, v_cnt, h_len, v_len, h_pos, v_pos;
    logic frame_pend, line_bad;
    logic h_edge, v_edge, frame_start, line_err, timeout, frame_good, de_nxt;

    // Two-stage input registers plus a third sync stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_h <= 1'b0; s2_h <= 1'b0; s3_h <= 1'b0;
            s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
            s1_r <= '0; s1_g <= '0; s1_b <= '0;
            s2_r <= '0; s2_g <= '0; s2_b <= '0;
        end else begin
            s1_h <= i_hsync; s2_h <= s1_h; s3_h <= s2_h;
            s1_v <= i_vsync; s2_v <= s1_v; s3_v <= s2_v;
            s1_r <= i_red;   s2_r <= s1_r;
            s1_g <= i_green; s2_g <= s1_g;
            s1_b <= i_blue;  s2_b <= s1_b;
        end
    end

    // Edge strobes, line/frame checks and the position of the pixel now in s2
    always_comb begin
        h_edge      = (s2_h == POL) && (s3_h != POL);
        v_edge      = (s2_v == POL) && (s3_v != POL);
        frame_start = h_edge && (frame_pend || v_edge);
        h_len       = h_cnt + 1'b1;
        v_len       = v_cnt + 1'b1;
        line_err    = h_edge && (h_len != TOT_C);
        timeout     = (h_cnt == CNT_MAX);
        // A short/long line on the frame-start edge belongs to the ending frame
        frame_good  = (v_len == TOT_R) && !line_bad && !line_err;
        h_pos       = h_edge ? '0 : (timeout ? h_cnt : h_len);
        v_pos       = v_cnt;
        if (frame_start) begin
            v_pos = '0;
        end else if (h_edge && (v_cnt != CNT_MAX)) begin
            v_pos = v_len;
        end
    end

    // Horizontal/vertical counters and the measured line/frame totals
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            frame_pend    <= 1'b0;
            line_bad      <= 1'b0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
        end else begin
            h_cnt <= h_pos;
            v_cnt <= v_pos;
            if (h_edge) begin
                o_line_len <= h_len;
            end
            if (frame_start) begin
                o_frame_lines <= v_len;
                frame_pend    <= 1'b0;
                line_bad      <= 1'b0;
            end else begin
                if (v_edge) begin
                    frame_pend <= 1'b1;
                end
                if (line_err) begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Lock FSM next state; lock-loss takes priority over a frame start
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_start && !timeout) begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (frame_start) begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 >= LOCK_N) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_err || timeout || (frame_start && !frame_good)) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
    end

    assign o_locked = (state == LOCKED);

    // Active-window decode for the pixel leaving s2
    always_comb begin
        de_nxt = (state_nxt == LOCKED) &&
                 (h_pos >= H_LO) && (h_pos < H_HI) &&
                 (v_pos >= V_LO) && (v_pos < V_HI);
    end

    // Registered pixel outputs, zeroed outside the active window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de    <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_err   <= 1'b0;
        end else begin
            o_de    <= de_nxt;
            o_x     <= de_nxt ? (h_pos - H_LO) : '0;
            o_y     <= de_nxt ? (v_pos - V_LO) : '0;
            o_red   <= de_nxt ? s2_r : '0;
            o_green <= de_nxt ? s2_g : '0;
            o_blue  <= de_nxt ? s2_b : '0;
            o_err   <= err_nxt;
        end
    end

endmodule

// File: doc/vga_timing_detector.md
Name: vga_timing_detector

Overview:
- Receive-side counterpart of the VGA sync/pattern transmit chain. Runs on pixel clock i_clk.
- Accepts hsync, vsync and 3-bit RGB from an upstream VGA source and recovers line and frame timing.
- Declares lock once timing matches expected totals for LOCK_FRAMES frames, then emits data-enable plus active-pixel x/y and pixel data.
- Sits in front of any capture/checker logic that needs pixel coordinates from a raw sync stream.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
TOTAL_COLS, 800, expected clocks per line
TOTAL_ROWS, 525, expected lines per frame
ACTIVE_COLS, 640, active pixels per line
ACTIVE_ROWS, 480, active lines per frame
H_START, 144, clocks from hsync leading edge to first active pixel
V_START, 35, lines from frame-start line to first active line
SYNC_POL, 0, sync pulse level (0 = active-low pulse)
LOCK_FRAMES, 2, consecutive good frames required to lock
CNT_W, 12, counter width

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  reset
i_hsync  in  1  incoming horizontal sync
i_vsync  in  1  incoming vertical sync
i_red/i_green/i_blue  in  VIDEO_WIDTH each  incoming pixel data
o_locked  out  1  timing locked
o_de  out  1  active pixel valid
o_x  out  CNT_W  active column, 0..ACTIVE_COLS-1
o_y  out  CNT_W  active row, 0..ACTIVE_ROWS-1
o_red/o_green/o_blue  out  VIDEO_WIDTH each  pixel data aligned to o_de
o_line_len  out  CNT_W  last measured line length
o_frame_lines  out  CNT_W  last measured lines per frame
o_err  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset and clocking:
  - One clock domain, i_clk. i_rst_n is asynchronous and active-low.
  - While reset is asserted, all outputs and state are 0 and the FSM is in SEARCH.
  - Reset mid-frame drops lock immediately, with no o_err pulse.
- Input path:
  - hsync, vsync and RGB pass through two register stages (s1, s2), then one extra sync stage (s3) for edge detection.
  - Leading edge = s2 at pulse level (== SYNC_POL) and s3 not at pulse level.
  - h_edge and v_edge are single-cycle strobes.
- Horizontal counting:
  - On h_edge: h_cnt <= 0 and o_line_len <= h_cnt+1.
  - Otherwise h_cnt increments, saturating at 2^CNT_W-1.
  - Reaching saturation = timeout.
- Vertical counting:
  - v_edge sets frame_pend.
  - The first h_edge in the same cycle as, or after, frame_pend is the frame start: v_cnt <= 0, o_frame_lines <= v_cnt+1, frame_pend cleared.
  - Any other h_edge: v_cnt <= v_cnt+1 (saturating).
- Line error: an h_edge with h_cnt+1 != TOTAL_COLS. Sets line_bad, which is cleared at each frame start.
- Frame good: at frame start, v_cnt+1 == TOTAL_ROWS and line_bad == 0 (including a line error on the frame-start edge itself).
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH: first frame start -> MEASURE with good_cnt = 0. The line/frame result of that edge is ignored.
  - MEASURE, at each frame start: frame good -> good_cnt+1, and if it reaches LOCK_FRAMES -> LOCKED next cycle; frame bad -> good_cnt = 0, stay in MEASURE.
  - LOCKED: line error, bad frame, or timeout -> SEARCH with o_err = 1 for exactly one cycle.
  - Timeout in SEARCH or MEASURE -> SEARCH, no o_err.
- o_locked = (state == LOCKED), registered.
- Outputs (registered, one stage after s2):
  - o_de = locked && H_START <= h_cnt < H_START+ACTIVE_COLS && V_START <= v_cnt < V_START+ACTIVE_ROWS.
  - o_x = h_cnt-H_START and o_y = v_cnt-V_START when o_de = 1, else 0.
  - o_rgb = s2 RGB when o_de = 1, else 0.
- Latency: a pixel at the pins at cycle t appears on o_rgb at t+3.
- Simultaneous events: h_edge and v_edge in the same cycle count as a frame start on that cycle. Lock-loss and frame start in the same cycle: lock-loss wins.

Test Plan:
- Nominal 800x525 stream, SYNC_POL=0, LOCK_FRAMES=2, started mid-frame -> o_locked rises 1 cycle after the 3rd frame start; o_line_len=800, o_frame_lines=525; exactly 307200 o_de cycles per locked frame; o_x 0..639 and o_y 0..479 with no gaps.
- Pixel pattern where RGB = column mod 8 -> while o_de, o_red == o_x mod 8; pipeline latency = 3 cycles.
- Locked, then one line shortened to 799 -> o_err single pulse at that h_edge; o_locked=0; relock after 2 further good frames.
- Locked, then hsync held inactive -> after 4095 cycles o_err pulses, o_locked=0, o_de stays 0.
- Stream with 524 lines/frame -> never locks; o_frame_lines=524; o_de stays 0.
- Assert i_rst_n=0 mid-active-line while locked -> all outputs 0 asynchronously with no o_err; after release, lock is reacquired after 2 good frames.
